// File: rtl/vga_pkg.sv
// Shared VGA definitions: resolution, counter/colour widths and the timing bundle
// passed between pipeline stages.
package vga_pkg;

  localparam int unsigned H_RES = 800;
  localparam int unsigned V_RES = 600;
  localparam int unsigned CNT_W = 11;
  localparam int unsigned RGB_W = 12;

  typedef enum logic {
    POS_IDLE = 1'b0,
    POS_HELD = 1'b1
  } pos_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hs;
    logic             vs;
    logic             hblnk;
    logic             vblnk;
  } vga_timing_t;

  function automatic logic [CNT_W-1:0] clamp_pos(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/pos_update_ctl.sv
// Sprite position handshake: captures clamped requests, acks them, and commits
// the pending position to the active one only on a vblank rising edge.
module pos_update_ctl
  import vga_pkg::*;
#(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned X_INIT = 0,
  parameter int unsigned Y_INIT = 0
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vblnk_in,
  input  logic             pos_req,
  input  logic [CNT_W-1:0] xpos_in,
  input  logic [CNT_W-1:0] ypos_in,
  output logic             pos_ack,
  output logic [CNT_W-1:0] active_x,
  output logic [CNT_W-1:0] active_y
);

  localparam logic [CNT_W-1:0] X_MAX = CNT_W'(H_RES - IMG_W);
  localparam logic [CNT_W-1:0] Y_MAX = CNT_W'(V_RES - IMG_H);

  pos_state_e       state, state_nxt;
  logic [CNT_W-1:0] pend_x, pend_y, pend_x_nxt, pend_y_nxt;
  logic [CNT_W-1:0] act_x_nxt, act_y_nxt;
  logic             vblnk_q;
  logic             ack_nxt;
  logic             vblnk_rise;
  logic [CNT_W-1:0] x_clamp, y_clamp;

  assign vblnk_rise = vblnk_in & ~vblnk_q;
  assign x_clamp    = clamp_pos(xpos_in, X_MAX);
  assign y_clamp    = clamp_pos(ypos_in, Y_MAX);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state    <= POS_IDLE;
      pend_x   <= '0;
      pend_y   <= '0;
      active_x <= CNT_W'(X_INIT);
      active_y <= CNT_W'(Y_INIT);
      vblnk_q  <= 1'b0;
      pos_ack  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend_x   <= pend_x_nxt;
      pend_y   <= pend_y_nxt;
      active_x <= act_x_nxt;
      active_y <= act_y_nxt;
      vblnk_q  <= vblnk_in;
      pos_ack  <= ack_nxt;
    end
  end

  // A request arriving on the commit edge bypasses pending and lands in active at once.
  always_comb begin
    state_nxt  = state;
    pend_x_nxt = pend_x;
    pend_y_nxt = pend_y;
    act_x_nxt  = active_x;
    act_y_nxt  = active_y;
    ack_nxt    = 1'b0;
    if (pos_req) begin
      ack_nxt    = 1'b1;
      pend_x_nxt = x_clamp;
      pend_y_nxt = y_clamp;
      if (vblnk_rise) begin
        act_x_nxt = x_clamp;
        act_y_nxt = y_clamp;
        state_nxt = POS_IDLE;
      end else begin
        state_nxt = POS_HELD;
      end
    end else if (state == POS_HELD && vblnk_rise) begin
      act_x_nxt = pend_x;
      act_y_nxt = pend_y;
      state_nxt = POS_IDLE;
    end
  end

endmodule

// File: rtl/image_addr_gen.sv
// Image ROM address generator: maps the VGA beam position onto a sprite-relative
// ROM address with a 2-cycle pipeline, keeping the timing signals aligned.
module image_addr_gen
  import vga_pkg::*;
#(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned H_RES_P = H_RES,
  parameter int unsigned V_RES_P = V_RES,
  parameter int unsigned X_INIT = 0,
  parameter int unsigned Y_INIT = 0,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [10:0]       hcount_in,
  input  logic [10:0]       vcount_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic              pos_req,
  input  logic [10:0]       xpos_in,
  input  logic [10:0]       ypos_in,
  output logic              pos_ack,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              img_en,
  output logic [10:0]       hcount,
  output logic [10:0]       vcount,
  output logic              hs_out,
  output logic              vs_out,
  output logic              hblnk,
  output logic              vblnk
);

  localparam int unsigned XB = $clog2(IMG_W);
  localparam int unsigned YB = $clog2(IMG_H);

  logic [CNT_W-1:0] active_x, active_y;
  logic [CNT_W:0]   rel_x_c, rel_y_c;
  logic             inside_c;
  logic [XB-1:0]    rel_x_q;
  logic [YB-1:0]    rel_y_q;
  logic             inside_q;
  vga_timing_t      tim_in_c, tim1_q, tim2_q;

  pos_update_ctl #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .X_INIT (X_INIT),
    .Y_INIT (Y_INIT)
  ) u_pos_ctl (
    .pclk     (pclk),
    .rst      (rst),
    .vblnk_in (vblnk_in),
    .pos_req  (pos_req),
    .xpos_in  (xpos_in),
    .ypos_in  (ypos_in),
    .pos_ack  (pos_ack),
    .active_x (active_x),
    .active_y (active_y)
  );

  // 12-bit two's complement offsets; the sign bit rejects pixels left of/above the image.
  assign rel_x_c  = {1'b0, hcount_in} - {1'b0, active_x};
  assign rel_y_c  = {1'b0, vcount_in} - {1'b0, active_y};
  assign inside_c = ~rel_x_c[CNT_W] && (rel_x_c < (CNT_W+1)'(IMG_W)) &&
                    ~rel_y_c[CNT_W] && (rel_y_c < (CNT_W+1)'(IMG_H)) &&
                    ~hblnk_in && ~vblnk_in;

  assign tim_in_c = '{hcount: hcount_in, vcount: vcount_in, hs: hs_in, vs: vs_in,
                      hblnk: hblnk_in, vblnk: vblnk_in};

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      rel_x_q  <= '0;
      rel_y_q  <= '0;
      inside_q <= 1'b0;
      tim1_q   <= '0;
      rom_addr <= '0;
      img_en   <= 1'b0;
      tim2_q   <= '0;
    end else begin
      rel_x_q  <= rel_x_c[XB-1:0];
      rel_y_q  <= rel_y_c[YB-1:0];
      inside_q <= inside_c;
      tim1_q   <= tim_in_c;
      rom_addr <= inside_q ? ADDR_W'({rel_y_q, rel_x_q}) : '0;
      img_en   <= inside_q;
      tim2_q   <= tim1_q;
    end
  end

  assign hcount = tim2_q.hcount;
  assign vcount = tim2_q.vcount;
  assign hs_out = tim2_q.hs;
  assign vs_out = tim2_q.vs;
  assign hblnk  = tim2_q.hblnk;
  assign vblnk  = tim2_q.vblnk;

endmodule

// File: tb/tb_image_addr_gen.sv
// Directed bench for image_addr_gen: an arithmetic reference model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_image_addr_gen;

  logic        pclk;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hs_in, vs_in, hblnk_in, vblnk_in;
  logic        pos_req;
  logic [10:0] xpos_in, ypos_in;
  logic        pos_ack;
  logic [11:0] rom_addr;
  logic        img_en;
  logic [10:0] hcount, vcount;
  logic        hs_out, vs_out, hblnk, vblnk;

  image_addr_gen dut (
    .pclk      (pclk),
    .rst       (rst),
    .hcount_in (hcount_in),
    .vcount_in (vcount_in),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .hblnk_in  (hblnk_in),
    .vblnk_in  (vblnk_in),
    .pos_req   (pos_req),
    .xpos_in   (xpos_in),
    .ypos_in   (ypos_in),
    .pos_ack   (pos_ack),
    .rom_addr  (rom_addr),
    .img_en    (img_en),
    .hcount    (hcount),
    .vcount    (vcount),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .hblnk     (hblnk),
    .vblnk     (vblnk)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  typedef struct {
    int addr;
    int en;
    int h, v, hs, vs, hb, vb;
  } exp_t;

  int   n_checks = 0;
  int   n_err    = 0;
  int   m_ax, m_ay, m_px, m_py;
  bit   m_held, m_prev_vb;
  int   m_ack;
  exp_t e1, e2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t z;
    z.addr = 0; z.en = 0; z.h = 0; z.v = 0; z.hs = 0; z.vs = 0; z.hb = 0; z.vb = 0;
    return z;
  endfunction

  // What the outputs must show for a given beam position and active sprite origin.
  function automatic exp_t predict(int h, int v, int hs, int vs, int hb, int vb, int ax, int ay);
    exp_t r;
    int rx, ry;
    rx = h - ax;
    ry = v - ay;
    r.en   = (rx >= 0 && rx < 64 && ry >= 0 && ry < 64 && hb == 0 && vb == 0) ? 1 : 0;
    r.addr = (r.en != 0) ? ry * 64 + rx : 0;
    r.h = h; r.v = v; r.hs = hs; r.vs = vs; r.hb = hb; r.vb = vb;
    return r;
  endfunction

  task automatic model_reset();
    m_ax = 0; m_ay = 0; m_px = 0; m_py = 0;
    m_held = 1'b0; m_prev_vb = 1'b0; m_ack = 0;
    e1 = zero_exp();
    e2 = zero_exp();
  endtask

  // Advance the model by one clock using the inputs that were just sampled.
  task automatic model_step();
    bit rise;
    int cx, cy;
    e2 = e1;
    e1 = predict(int'(hcount_in), int'(vcount_in), int'(hs_in), int'(vs_in),
                 int'(hblnk_in), int'(vblnk_in), m_ax, m_ay);
    rise  = vblnk_in && !m_prev_vb;
    m_ack = int'(pos_req);
    if (pos_req) begin
      cx = (int'(xpos_in) > 736) ? 736 : int'(xpos_in);
      cy = (int'(ypos_in) > 536) ? 536 : int'(ypos_in);
      m_px = cx; m_py = cy;
      if (rise) begin
        m_ax = cx; m_ay = cy; m_held = 1'b0;
      end else begin
        m_held = 1'b1;
      end
    end else if (m_held && rise) begin
      m_ax = m_px; m_ay = m_py; m_held = 1'b0;
    end
    m_prev_vb = vblnk_in;
  endtask

  task automatic drive(input int h, input int v, input int hb, input int vb,
                       input int req, input int x, input int y);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hs_in     = 1'($urandom_range(0, 1));
    vs_in     = 1'($urandom_range(0, 1));
    hblnk_in  = 1'(hb);
    vblnk_in  = 1'(vb);
    pos_req   = 1'(req);
    xpos_in   = 11'(x);
    ypos_in   = 11'(y);
    @(posedge pclk);
    if (rst) model_reset();
    else     model_step();
    #1;
  endtask

  // Present one pixel, flush it through with a blanked pixel, then check it literally.
  task automatic probe(input string name, input int h, input int v, input int hb, input int vb,
                       input int exp_en, input int exp_addr);
    drive(h, v, hb, vb, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    chk({name, ".en"}, 32'(img_en), 32'(exp_en));
    chk({name, ".addr"}, 32'(rom_addr), 32'(exp_addr));
  endtask

  task automatic vblank_rise();
    drive(0, 600, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge pclk);
      chk("cyc.rom_addr", 32'(rom_addr), 32'(e2.addr));
      chk("cyc.img_en",   32'(img_en),   32'(e2.en));
      chk("cyc.hcount",   32'(hcount),   32'(e2.h));
      chk("cyc.vcount",   32'(vcount),   32'(e2.v));
      chk("cyc.hs",       32'(hs_out),   32'(e2.hs));
      chk("cyc.vs",       32'(vs_out),   32'(e2.vs));
      chk("cyc.hblnk",    32'(hblnk),    32'(e2.hb));
      chk("cyc.vblnk",    32'(vblnk),    32'(e2.vb));
      chk("cyc.pos_ack",  32'(pos_ack),  32'(m_ack));
    end
  end

  initial begin
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0; hs_in = 1'b0; vs_in = 1'b0;
    hblnk_in = 1'b0; vblnk_in = 1'b0; pos_req = 1'b0; xpos_in = '0; ypos_in = '0;
    model_reset();
    drive(5, 5, 0, 0, 0, 0, 0);
    drive(5, 5, 0, 0, 0, 0, 0);
    chk("reset.img_en", 32'(img_en), 32'd0);
    chk("reset.rom_addr", 32'(rom_addr), 32'd0);
    chk("reset.pos_ack", 32'(pos_ack), 32'd0);
    rst = 1'b0;

    // 1: default origin
    probe("t1.origin", 0, 0, 0, 0, 1, 0);
    probe("t1.right_edge", 63, 0, 0, 0, 1, 63);
    probe("t1.past_right", 64, 0, 0, 0, 0, 0);
    probe("t1.bottom_left", 0, 63, 0, 0, 1, 4032);

    // 2: request during visible area, committed at vblank
    drive(10, 10, 0, 0, 1, 100, 50);
    chk("t2.ack", 32'(pos_ack), 32'd1);
    drive(11, 10, 0, 0, 0, 0, 0);
    chk("t2.ack_clear", 32'(pos_ack), 32'd0);
    probe("t2.still_old", 0, 0, 0, 0, 1, 0);
    vblank_rise();
    probe("t2.tl", 100, 50, 0, 0, 1, 0);
    probe("t2.tr", 163, 50, 0, 0, 1, 63);
    probe("t2.row1", 100, 51, 0, 0, 1, 64);
    probe("t2.br", 163, 113, 0, 0, 1, 4095);
    probe("t2.left", 99, 50, 0, 0, 0, 0);
    probe("t2.above", 100, 49, 0, 0, 0, 0);

    // 3: mid-frame request does not tear the current frame
    drive(0, 200, 0, 0, 1, 300, 300);
    chk("t3.ack", 32'(pos_ack), 32'd1);
    probe("t3.old_pos", 110, 60, 0, 0, 1, 650);
    vblank_rise();
    probe("t3.new_tl", 300, 300, 0, 0, 1, 0);
    probe("t3.new_br", 363, 363, 0, 0, 1, 4095);
    probe("t3.old_gone", 110, 60, 0, 0, 0, 0);

    // 4: clamping, then last-request-wins
    drive(0, 10, 0, 0, 1, 790, 590);
    vblank_rise();
    probe("t4.clamp_tl", 736, 536, 0, 0, 1, 0);
    probe("t4.clamp_br", 799, 599, 0, 0, 1, 4095);
    probe("t4.clamp_left", 735, 536, 0, 0, 0, 0);
    drive(0, 10, 0, 0, 1, 10, 10);
    chk("t4.ack1", 32'(pos_ack), 32'd1);
    drive(0, 11, 0, 0, 1, 20, 20);
    chk("t4.ack2", 32'(pos_ack), 32'd1);
    vblank_rise();
    probe("t4.last_wins", 20, 20, 0, 0, 1, 0);
    probe("t4.first_lost", 10, 10, 0, 0, 0, 0);

    // 5: request on the rising-edge cycle, blanking masks
    drive(0, 600, 1, 1, 1, 40, 40);
    chk("t5.ack", 32'(pos_ack), 32'd1);
    drive(0, 601, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    probe("t5.direct", 40, 40, 0, 0, 1, 0);
    probe("t5.hblank", 41, 41, 1, 0, 0, 0);
    probe("t5.vblank", 41, 41, 0, 1, 0, 0);
    probe("t5.idle_rise", 41, 41, 0, 0, 1, 65);

    // 6: async reset with an update pending
    drive(45, 45, 0, 0, 1, 500, 500);
    drive(46, 45, 0, 0, 0, 0, 0);
    chk("t6.pre_en", 32'(img_en), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6.async_en", 32'(img_en), 32'd0);
    chk("t6.async_addr", 32'(rom_addr), 32'd0);
    chk("t6.async_hcount", 32'(hcount), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    vblank_rise();
    probe("t6.init_pos", 0, 0, 0, 0, 1, 0);
    probe("t6.no_commit", 500, 500, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
